// File: rtl/hazard_control_unit_if.sv
// Hazard controller bundle: pipeline fields in, stall/flush/forward and event counters out.
//   master : pipeline side (drives the decode/execute/memory/writeback fields)
//   slave  : hazard_control_unit (drives stall, flush, forwarding and counters)
interface hazard_control_unit_if #(
  parameter int unsigned CNT_W = 32
);
  localparam int unsigned REG_W = 5;

  logic [REG_W-1:0] Rs1D;
  logic [REG_W-1:0] Rs2D;
  logic             UsesRs1D;
  logic             UsesRs2D;
  logic [REG_W-1:0] Rs1E;
  logic [REG_W-1:0] Rs2E;
  logic [REG_W-1:0] RdE;
  logic             MemReadE;
  logic             BranchE;
  logic             JumpE;
  logic             MuxjalrE;
  logic             BranchTakenE;
  logic [REG_W-1:0] RdM;
  logic             RegWriteM;
  logic [REG_W-1:0] RdW;
  logic             RegWriteW;

  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output Rs1D, Rs2D, UsesRs1D, UsesRs2D, Rs1E, Rs2E, RdE,
    output MemReadE, BranchE, JumpE, MuxjalrE, BranchTakenE,
    output RdM, RegWriteM, RdW, RegWriteW,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
    input  StallCount, FlushCount
  );

  modport slave (
    input  Rs1D, Rs2D, UsesRs1D, UsesRs2D, Rs1E, Rs2E, RdE,
    input  MemReadE, BranchE, JumpE, MuxjalrE, BranchTakenE,
    input  RdM, RegWriteM, RdW, RegWriteW,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
    output StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller for the five-stage RV32I core.
// Detects load-use hazards (multi-cycle interlock via a RUN/LOAD_STALL FSM),
// flushes on branch/jump redirects, selects execute-stage operand forwarding
// and keeps saturating stall/flush event counters.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   hz    : hazard bundle (slave side) -- pipeline fields in, controls out
// Stall/flush/forward outputs are combinational; counters are registered.
module hazard_control_unit #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  hazard_control_unit_if.slave  hz
);
  localparam int unsigned   REG_W    = 5;
  localparam logic [1:0]    CNT_INIT = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    RUN,
    LOAD_STALL
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic load_use_c;
  logic redirect_c;
  logic stall_c;
  logic flush_d_c;
  logic flush_e_c;

  // Forward select: memory stage wins over writeback; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rd_m,
    input logic             wr_m,
    input logic [REG_W-1:0] rd_w,
    input logic             wr_w
  );
    if (wr_m && (rd_m != '0) && (rd_m == rs)) begin
      return 2'b10;
    end else if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  // Hazard detection on the current decode/execute contents.
  always_comb begin
    load_use_c = hz.MemReadE && (hz.RdE != '0) &&
                 ((hz.UsesRs1D && (hz.Rs1D == hz.RdE)) ||
                  (hz.UsesRs2D && (hz.Rs2D == hz.RdE)));
    redirect_c = (hz.BranchE && hz.BranchTakenE) || hz.JumpE || hz.MuxjalrE;
  end

  // Next-state and control outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_c   = 1'b0;
    flush_d_c = 1'b0;
    flush_e_c = 1'b0;

    case (state_q)
      RUN: begin
        // A redirect means the execute slot is a branch/jump, so it cannot
        // also be a load; if both show up the redirect is honoured alone.
        if (redirect_c) begin
          flush_d_c = 1'b1;
          flush_e_c = 1'b1;
        end else if (load_use_c) begin
          stall_c   = 1'b1;
          flush_e_c = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = LOAD_STALL;
            cnt_d   = CNT_INIT;
          end
        end
      end
      LOAD_STALL: begin
        // Execute holds a bubble here, so hazard inputs are not looked at.
        stall_c   = 1'b1;
        flush_e_c = 1'b1;
        cnt_d     = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 2'd0;
      end
    endcase

    // Controls are held low for the whole reset window.
    if (reset) begin
      stall_c   = 1'b0;
      flush_d_c = 1'b0;
      flush_e_c = 1'b0;
    end
  end

  // Saturating event counters.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall_c && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
    if (flush_d_c && (flush_count_q != CNT_MAX)) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      cnt_q         <= 2'd0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign hz.StallF     = stall_c;
  assign hz.StallD     = stall_c;
  assign hz.FlushD     = flush_d_c;
  assign hz.FlushE     = flush_e_c;
  assign hz.ForwardAE  = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
  assign hz.ForwardBE  = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
  assign hz.StallCount = stall_count_q;
  assign hz.FlushCount = flush_count_q;
endmodule
